// File: rtl/gc_pkg.sv
// rtl/gc_pkg.sv - shared state encoding and constants for the game clock scoreboard
package gc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_PERIOD_END,
        ST_GAME_OVER
    } gc_state_t;

    localparam logic [5:0] SECS_PER_MIN = 6'd59;

    localparam logic [1:0] PTS_NONE  = 2'd0;
    localparam logic [1:0] PTS_ONE   = 2'd1;
    localparam logic [1:0] PTS_TWO   = 2'd2;
    localparam logic [1:0] PTS_THREE = 2'd3;

endpackage

// File: rtl/game_clock_scoreboard_if.sv
// rtl/game_clock_scoreboard_if.sv - control pulses in, clock/score display values out
interface game_clock_scoreboard_if #(
  parameter int NUM_TEAMS = 2,
  parameter int SCORE_W   = 8
);
  logic                         start_stop;
  logic                         clear_game;
  logic                         score_strobe;
  logic [2:0]                   score_team;
  logic [1:0]                   score_pts;
  logic                         score_sub;
  logic [5:0]                   minutes;
  logic [5:0]                   seconds;
  logic [3:0]                   period;
  logic                         running;
  logic                         buzzer;
  logic                         game_over;
  logic [NUM_TEAMS*SCORE_W-1:0] scores;

  modport master (
    output start_stop, clear_game, score_strobe, score_team, score_pts, score_sub,
    input  minutes, seconds, period, running, buzzer, game_over, scores
  );

  modport slave (
    input  start_stop, clear_game, score_strobe, score_team, score_pts, score_sub,
    output minutes, seconds, period, running, buzzer, game_over, scores
  );
endinterface

// File: rtl/game_countdown_timer.sv
// rtl/game_countdown_timer.sv - one-second prescaler and mm:ss countdown with zero detect
module game_countdown_timer
  import gc_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int PERIOD_MIN    = 12
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  input  logic       load,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       final_tick
);
  localparam int CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic             tick;

  // When run is low the prescaler simply holds, so a resumed second keeps its remainder.
  assign tick       = run && (cnt_q == CNT_W'(TICKS_PER_SEC - 1));
  assign final_tick = tick && (minutes == 6'd0) && (seconds <= 6'd1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      minutes <= 6'(PERIOD_MIN);
      seconds <= '0;
    end else if (load) begin
      cnt_q   <= '0;
      minutes <= 6'(PERIOD_MIN);
      seconds <= '0;
    end else if (run) begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
      if (tick) begin
        if (seconds != 6'd0) begin
          seconds <= seconds - 6'd1;
        end else if (minutes != 6'd0) begin
          seconds <= SECS_PER_MIN;
          minutes <= minutes - 6'd1;
        end
      end
    end
  end
endmodule

// File: rtl/game_clock_scoreboard.sv
// rtl/game_clock_scoreboard.sv - game clock FSM with saturating per-team score bank
module game_clock_scoreboard
  import gc_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int NUM_TEAMS     = 2,
  parameter int SCORE_W       = 8,
  parameter int SCORE_MAX     = 199,
  parameter int PERIOD_MIN    = 12,
  parameter int NUM_PERIODS   = 4
) (
  input logic                    clock,
  input logic                    reset,
  game_clock_scoreboard_if.slave bus
);
  localparam logic [SCORE_W:0] MAX_W = (SCORE_W + 1)'(SCORE_MAX);

  gc_state_t  state_q, state_d;
  logic [3:0] period_q;
  logic       buzzer_q;
  logic       timer_load, period_inc, final_tick, run;
  logic [5:0] minutes, seconds;
  logic [NUM_TEAMS*SCORE_W-1:0] scores_flat;

  assign run = (state_q == ST_RUN);

  game_countdown_timer #(
    .TICKS_PER_SEC(TICKS_PER_SEC),
    .PERIOD_MIN   (PERIOD_MIN)
  ) u_timer (
    .clock     (clock),
    .reset     (reset),
    .run       (run),
    .load      (timer_load),
    .minutes   (minutes),
    .seconds   (seconds),
    .final_tick(final_tick)
  );

  always_comb begin
    state_d    = state_q;
    timer_load = 1'b0;
    period_inc = 1'b0;
    if (bus.clear_game) begin
      state_d    = ST_IDLE;
      timer_load = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE:  if (bus.start_stop) state_d = ST_RUN;
        // The last tick of a period beats a coincident start_stop.
        ST_RUN: begin
          if (final_tick)
            state_d = (period_q < 4'(NUM_PERIODS)) ? ST_PERIOD_END : ST_GAME_OVER;
          else if (bus.start_stop)
            state_d = ST_PAUSE;
        end
        ST_PAUSE: if (bus.start_stop) state_d = ST_RUN;
        ST_PERIOD_END: begin
          if (bus.start_stop) begin
            state_d    = ST_PAUSE;
            timer_load = 1'b1;
            period_inc = 1'b1;
          end
        end
        ST_GAME_OVER: state_d = ST_GAME_OVER;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      period_q <= 4'd1;
      buzzer_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      buzzer_q <= final_tick && !bus.clear_game;
      if (bus.clear_game)  period_q <= 4'd1;
      else if (period_inc) period_q <= period_q + 4'd1;
    end
  end

  for (genvar i = 0; i < NUM_TEAMS; i++) begin : g_team
    logic [SCORE_W-1:0] score_q;
    logic [SCORE_W:0]   wide, pts_w, sum;
    logic               hit;

    assign wide  = {1'b0, score_q};
    assign pts_w = (SCORE_W + 1)'(bus.score_pts);
    assign sum   = wide + pts_w;
    // Out-of-range team indices match no slot and are dropped naturally.
    assign hit   = bus.score_strobe && (bus.score_pts != PTS_NONE) &&
                   (bus.score_team == 3'(i)) && (state_q != ST_GAME_OVER);

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        score_q <= '0;
      end else if (bus.clear_game) begin
        score_q <= '0;
      end else if (hit) begin
        if (bus.score_sub)
          score_q <= (wide < pts_w) ? '0 : SCORE_W'(wide - pts_w);
        else
          score_q <= (sum > MAX_W) ? SCORE_W'(SCORE_MAX) : sum[SCORE_W-1:0];
      end
    end

    assign scores_flat[i*SCORE_W +: SCORE_W] = score_q;
  end

  assign bus.minutes   = minutes;
  assign bus.seconds   = seconds;
  assign bus.period    = period_q;
  assign bus.running   = run;
  assign bus.buzzer    = buzzer_q;
  assign bus.game_over = (state_q == ST_GAME_OVER);
  assign bus.scores    = scores_flat;
endmodule

// File: tb/tb_game_clock_scoreboard.sv
// tb/tb_game_clock_scoreboard.sv - self-checking bench for game_clock_scoreboard
module tb_game_clock_scoreboard;
  localparam int T    = 10;
  localparam int PM   = 1;
  localparam int NP   = 2;
  localparam int NT   = 2;
  localparam int SW   = 8;
  localparam int SMAX = 199;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  game_clock_scoreboard_if #(.NUM_TEAMS(NT), .SCORE_W(SW)) bus ();

  game_clock_scoreboard #(
    .TICKS_PER_SEC(T), .NUM_TEAMS(NT), .SCORE_W(SW), .SCORE_MAX(SMAX),
    .PERIOD_MIN(PM), .NUM_PERIODS(NP)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: states 0 idle, 1 run, 2 pause, 3 period end, 4 game over.
  // Remaining time is derived from total cycles spent running in the period.
  int m_state, m_rc, m_period, m_buzz;
  int m_score[NT];

  typedef struct {
    int team; int pts; int sub; int exp0; int exp1;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic model_reset();
    m_state = 0; m_rc = 0; m_period = 1; m_buzz = 0;
    for (int i = 0; i < NT; i++) m_score[i] = 0;
  endtask

  task automatic model_edge(input int ss, input int clr, input int stb,
                            input int team, input int pts, input int sub);
    int old;
    int v;
    old = m_state;
    if (clr != 0) begin
      model_reset();
    end else begin
      m_buzz = 0;
      case (old)
        0: if (ss != 0) m_state = 1;
        1: begin
          m_rc++;
          if (m_rc == PM * 60 * T) begin
            m_buzz  = 1;
            m_state = (m_period < NP) ? 3 : 4;
          end else if (ss != 0) m_state = 2;
        end
        2: if (ss != 0) m_state = 1;
        3: if (ss != 0) begin m_period++; m_rc = 0; m_state = 2; end
        default: ;
      endcase
      if (stb != 0 && pts != 0 && old != 4 && team < NT) begin
        v = (sub != 0) ? m_score[team] - pts : m_score[team] + pts;
        if (v < 0) v = 0;
        if (v > SMAX) v = SMAX;
        m_score[team] = v;
      end
    end
  endtask

  task automatic compare_model();
    int rem, em, es;
    rem = PM * 60 - m_rc / T;
    em = rem / 60;
    es = rem % 60;
    n_checks++;
    if (int'(bus.minutes) == em && int'(bus.seconds) == es && int'(bus.period) == m_period &&
        bus.running == (m_state == 1) && int'(bus.buzzer) == m_buzz &&
        bus.game_over == (m_state == 4) &&
        int'(bus.scores[7:0]) == m_score[0] && int'(bus.scores[15:8]) == m_score[1])
      n_pass++;
    else
      $display("FAIL model t=%0t: got %0d:%0d p%0d r%0d b%0d g%0d s%0d/%0d expected %0d:%0d p%0d r%0d b%0d g%0d s%0d/%0d",
               $time, bus.minutes, bus.seconds, bus.period, bus.running, bus.buzzer, bus.game_over,
               bus.scores[7:0], bus.scores[15:8], em, es, m_period, (m_state == 1), m_buzz,
               (m_state == 4), m_score[0], m_score[1]);
  endtask

  task automatic cycle(input int ss, input int clr, input int stb,
                       input int team, input int pts, input int sub);
    bus.start_stop   = ss[0];
    bus.clear_game   = clr[0];
    bus.score_strobe = stb[0];
    bus.score_team   = team[2:0];
    bus.score_pts    = pts[1:0];
    bus.score_sub    = sub[0];
    @(posedge clock);
    model_edge(ss, clr, stb, team, pts, sub);
    #1;
    bus.start_stop = 1'b0; bus.clear_game = 1'b0; bus.score_strobe = 1'b0;
    bus.score_team = 3'd0; bus.score_pts = 2'd0; bus.score_sub = 1'b0;
    compare_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " minutes"}, int'(bus.minutes), PM);
    check({tag, " seconds"}, int'(bus.seconds), 0);
    check({tag, " period"}, int'(bus.period), 1);
    check({tag, " running"}, int'(bus.running), 0);
    check({tag, " buzzer"}, int'(bus.buzzer), 0);
    check({tag, " game_over"}, int'(bus.game_over), 0);
    check({tag, " scores"}, int'(bus.scores), 0);
  endtask

  initial begin
    tbl[0] = '{0, 2, 0, 2, 0};
    tbl[1] = '{0, 3, 1, 0, 0};
    tbl[2] = '{1, 3, 0, 0, 3};
    tbl[3] = '{5, 3, 0, 0, 3};
    tbl[4] = '{1, 0, 0, 0, 3};
    tbl[5] = '{0, 1, 0, 1, 3};
    tbl[6] = '{1, 1, 1, 1, 2};
    tbl[7] = '{7, 1, 1, 1, 2};

    bus.start_stop = 1'b0; bus.clear_game = 1'b0; bus.score_strobe = 1'b0;
    bus.score_team = 3'd0; bus.score_pts = 2'd0; bus.score_sub = 1'b0;
    model_reset();
    #12;
    check_reset_values("reset");
    #10 reset = 1'b1;
    @(posedge clock); #1;

    // Period 1 runs out: 599 cycles leave 00:01, the 600th writes 00:00 with buzzer.
    cycle(1, 0, 0, 0, 0, 0);
    check("running after start", int'(bus.running), 1);
    idle(599);
    check("one second left", int'(bus.seconds), 1);
    idle(1);
    check("zero minutes", int'(bus.minutes), 0);
    check("zero seconds", int'(bus.seconds), 0);
    check("buzzer on", int'(bus.buzzer), 1);
    check("stopped at period end", int'(bus.running), 0);
    idle(1);
    check("buzzer one cycle", int'(bus.buzzer), 0);
    check("period still 1", int'(bus.period), 1);

    cycle(1, 0, 0, 0, 0, 0);
    check("period advanced", int'(bus.period), 2);
    check("reloaded minutes", int'(bus.minutes), PM);
    check("paused after advance", int'(bus.running), 0);
    cycle(1, 0, 0, 0, 0, 0);
    idle(600);
    check("game over", int'(bus.game_over), 1);
    check("final buzzer", int'(bus.buzzer), 1);
    cycle(1, 0, 1, 0, 3, 0);
    cycle(0, 0, 1, 1, 2, 0);
    check("game over absorbing", int'(bus.game_over), 1);
    check("no score after game", int'(bus.scores), 0);

    // Pause with the prescaler at 7; resume needs exactly 3 more cycles.
    cycle(0, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    idle(6);
    cycle(1, 0, 0, 0, 0, 0);
    check("paused", int'(bus.running), 0);
    idle(50);
    check("held time", int'(bus.seconds), 0);
    cycle(1, 0, 0, 0, 0, 0);
    idle(2);
    check("no decrement yet", int'(bus.minutes), 1);
    idle(1);
    check("decrement 3 after resume", int'(bus.seconds), 59);

    // Scoring vectors from a clean start.
    cycle(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 1, tbl[i].team, tbl[i].pts, tbl[i].sub);
      check($sformatf("vec%0d team0", i), int'(bus.scores[7:0]), tbl[i].exp0);
      check($sformatf("vec%0d team1", i), int'(bus.scores[15:8]), tbl[i].exp1);
    end
    for (int i = 0; i < 65; i++) cycle(0, 0, 1, 1, 3, 0);
    cycle(0, 0, 1, 1, 1, 0);
    check("team1 at 198", int'(bus.scores[15:8]), 198);
    cycle(0, 0, 1, 1, 3, 0);
    check("team1 saturates", int'(bus.scores[15:8]), SMAX);
    cycle(0, 0, 1, 1, 2, 0);
    check("team1 stays max", int'(bus.scores[15:8]), SMAX);

    // clear_game beats start_stop and score_strobe mid-RUN.
    cycle(1, 0, 0, 0, 0, 0);
    idle(13);
    cycle(1, 1, 1, 0, 3, 0);
    check_reset_values("clear");

    // Asynchronous reset mid-second, between clock edges.
    cycle(1, 0, 0, 0, 0, 0);
    idle(15);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_reset_values("async");
    #1 reset = 1'b1;
    cycle(1, 0, 0, 0, 0, 0);
    idle(9);
    check("prescaler cleared", int'(bus.seconds), 0);
    idle(1);
    check("first tick after reset", int'(bus.seconds), 59);

    // Randomised traffic against the model.
    cycle(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 24) == 0) ? 1 : 0,
            ($urandom_range(0, 399) == 0) ? 1 : 0,
            ($urandom_range(0, 3) == 0) ? 1 : 0,
            int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
